// File: rtl/fir_out_arbiter.sv
// Round-robin arbiter sharing the FIR 8:1 result mux; drives sel/ch_ready and registers the muxed word.
// Accepted word appears on out_valid one cycle later; define FIR_ARB_FIXED_PRI_EN for lowest-index-first new grants.
module fir_out_arbiter #(
  parameter int OUT_DATA_WIDTH = 21,
  parameter int MAX_BURST      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                ch_valid,
  output logic [7:0]                ch_ready,
  output logic [2:0]                sel,
  input  logic [OUT_DATA_WIDTH-1:0] mux_data,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic [2:0]                out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t     state;
  logic [2:0] owner;
  logic [3:0] cnt;
  logic [2:0] sel_q;
  logic [2:0] new_win;
  logic [2:0] winner;
  logic       can_accept;
  logic       cont;
  logic       grant;

  assign can_accept = !out_valid || out_ready;
  assign cont       = (state == BURST) && ch_valid[owner] && (cnt < 4'(MAX_BURST));

`ifdef FIR_ARB_FIXED_PRI_EN
  always_comb begin
    new_win = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (ch_valid[i]) new_win = 3'(i);
    end
  end
`else
  logic [2:0] ptr;
  logic [2:0] idx;

  // Descending scan so the last hit is the first valid channel at or after ptr.
  always_comb begin
    new_win = ptr;
    idx     = ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (ch_valid[idx]) new_win = idx;
    end
  end
`endif

  assign winner   = cont ? owner : new_win;
  assign grant    = !rst && can_accept && (|ch_valid);
  assign ch_ready = grant ? (8'd1 << winner) : 8'd0;
  assign sel      = grant ? winner : sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 3'd0;
      cnt       <= 4'd0;
      sel_q     <= 3'd0;
      out_data  <= '0;
      out_ch    <= 3'd0;
      out_valid <= 1'b0;
`ifndef FIR_ARB_FIXED_PRI_EN
      ptr       <= 3'd0;
`endif
    end else if (can_accept) begin
      if (|ch_valid) begin
        sel_q     <= winner;
        out_data  <= mux_data;
        out_ch    <= winner;
        out_valid <= 1'b1;
        if (cont) begin
          cnt <= cnt + 4'd1;
        end else begin
          owner <= new_win;
          cnt   <= 4'd1;
          state <= BURST;
`ifndef FIR_ARB_FIXED_PRI_EN
          ptr   <= new_win + 3'd1;
`endif
        end
      end else begin
        out_valid <= 1'b0;
        state     <= IDLE;
        cnt       <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_arbiter.sv
// Directed scoreboard bench for fir_out_arbiter: expected words are queued per test, a monitor pops on each transfer.
module tb_fir_out_arbiter;
  localparam int W = 21;

  typedef struct packed {
    logic [2:0]   ch;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   ch_valid;
  logic [7:0]   ch_ready;
  logic [2:0]   sel;
  logic [W-1:0] mux_data;
  logic [W-1:0] out_data;
  logic [2:0]   out_ch;
  logic         out_valid;
  logic         out_ready;

  logic [W-1:0] ch_data [8];
  int           rem [8];
  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  always #5 clk = ~clk;

  assign mux_data = ch_data[sel];

  fir_out_arbiter #(.OUT_DATA_WIDTH(W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .sel       (sel),
    .mux_data  (mux_data),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic push(input int ch, input logic [W-1:0] data);
    exp_t e;
    e.ch   = 3'(ch);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_rem(input int ch, input int n);
    rem[ch]      = n;
    ch_valid[ch] = (n > 0);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 8; i++) set_rem(i, 0);
  endtask

  // One clock: note which producers were accepted, then retire their beats after the edge.
  task automatic step();
    logic [7:0] acc;
    @(negedge clk);
    acc = ch_valid & ch_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (acc[i]) rem[i]--;
      ch_valid[i] = (rem[i] > 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("ready_onehot", 32'($countones(ch_ready) <= 1), 32'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got ch %0d data %0h, required no word", out_ch, out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_ch", 32'(out_ch), 32'(e.ch));
          check("out_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    ch_valid  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rem[i]     = 0;
      ch_data[i] = W'(i);
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state with every channel requesting.
    for (int i = 0; i < 8; i++) set_rem(i, 100);
    #1;
    check("rst_ch_ready", 32'(ch_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_ch", 32'(out_ch), 32'h0);
    rst = 1'b0;

    // Mid-traffic reset: the second word is still pending and must vanish.
    push(0, W'(0));
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_ch_ready", 32'(ch_ready), 32'h0);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_sel", 32'(sel), 32'h0);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    step();
    rst = 1'b0;
    clear_all();

`ifndef FIR_ARB_FIXED_PRI_EN
    // Fairness: all channels busy, four beats each, wrapping back to ch0.
    for (int i = 0; i < 8; i++) begin
      ch_data[i] = W'(i);
      set_rem(i, (i == 0) ? 8 : 4);
    end
    for (int k = 0; k < 36; k++) push((k / 4) % 8, W'((k / 4) % 8));
    repeat (37) step();
    check("fair_drained", 32'(exp_q.size()), 32'd0);

    // Early rotate: ch2 drops after two beats, then returns.
    for (int i = 0; i < 8; i++) ch_data[i] = W'(32'h10000 | i);
    set_rem(2, 2);
    set_rem(5, 4);
    push(2, 21'h10002); push(2, 21'h10002);
    push(5, 21'h10005); push(5, 21'h10005); push(5, 21'h10005); push(5, 21'h10005);
    push(2, 21'h10002); push(2, 21'h10002);
    repeat (3) step();
    set_rem(2, 2);
    repeat (6) step();
    check("rotate_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: stall after two ch3 beats, burst count resumes afterwards.
    ch_data[3] = 21'h1ABCD;
    ch_data[4] = 21'h00444;
    set_rem(3, 6);
    set_rem(4, 2);
    push(3, 21'h1ABCD); push(3, 21'h1ABCD); push(3, 21'h1ABCD); push(3, 21'h1ABCD);
    push(4, 21'h00444); push(4, 21'h00444);
    push(3, 21'h1ABCD); push(3, 21'h1ABCD);
    repeat (2) step();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'h1ABCD);
      check("stall_out_ch", 32'(out_ch), 32'd3);
      check("stall_ch_ready", 32'(ch_ready), 32'h0);
      check("stall_sel", 32'(sel), 32'd3);
    end
    out_ready = 1'b1;
    repeat (7) step();
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Single requester keeps being granted every cycle.
    ch_data[7] = 21'h1F00F;
    set_rem(7, 6);
    for (int k = 0; k < 6; k++) push(7, 21'h1F00F);
    repeat (7) step();
    check("single_drained", 32'(exp_q.size()), 32'd0);
`else
    // Fixed priority: ch1 always wins new grants while it requests.
    ch_data[1] = 21'h00111;
    ch_data[6] = 21'h00666;
    set_rem(1, 6);
    set_rem(6, 3);
    for (int k = 0; k < 6; k++) push(1, 21'h00111);
    for (int k = 0; k < 3; k++) push(6, 21'h00666);
    repeat (10) step();
    check("fixed_drained", 32'(exp_q.size()), 32'd0);
`endif

    repeat (2) step();
    check("final_out_valid", 32'(out_valid), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_out_arbiter.md
# fir_out_arbiter

Round-robin arbiter that shares the FIR output path's 8:1 result mux between eight producing channels. It drives the mux select lines and samples the muxed word into a registered valid/ready output stage. Granted channels may stream short bursts before the grant rotates. It sits between the per-channel FIR result registers and the single downstream consumer.

## Interface
- OUT_DATA_WIDTH, 21, width of each channel result and of the output word
- MAX_BURST, 4, maximum consecutive beats per grant (1..15)

Ports:
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ch_valid  in  8  per-channel result valid, bit i = channel i
- ch_ready  out  8  one-hot accept; at most one bit high per cycle
- sel  out  3  select lines to the external combinational 8:1 mux
- mux_data  in  OUT_DATA_WIDTH  mux output, i.e. data of channel `sel`, same cycle
- out_data  out  OUT_DATA_WIDTH  registered output word
- out_ch  out  3  channel index of out_data
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept

## Operation
- can_accept = !out_valid || out_ready.
- State machine IDLE / BURST; registers owner[2:0], cnt[3:0], ptr[2:0].
- Continue condition: state==BURST && ch_valid[owner] && cnt<MAX_BURST → winner=owner, cnt+1.
- Otherwise, if any ch_valid: winner = first valid channel scanning ptr, ptr+1, …, ptr+7 (mod 8) → owner=winner, cnt=1, ptr=winner+1 mod 8, state=BURST. May re-select the expiring owner if it is the only requester.
- Grant only when can_accept and a winner exists: ch_ready[winner]=1, sel=winner, out_data←mux_data, out_ch←winner, out_valid←1.
- can_accept && no ch_valid: out_valid←0 if out_ready, state→IDLE, cnt→0.
- !can_accept: ch_ready=0, sel, owner, cnt, ptr and outputs hold.
- When no grant, sel holds its last value; it is never driven X.
- Reset values: out_valid 0, out_data 0, out_ch 0, sel 0, ptr 0, owner 0, cnt 0, state IDLE. ch_ready is forced 0 while rst is high.

## Timing
- sel and ch_ready are combinational from ch_valid, out_valid, out_ready and state. mux_data must settle in the same cycle.
- Latency: accepting edge (ch_valid & ch_ready) → out_valid on the next cycle. Sustained throughput is 1 word/cycle with out_ready held high.
- Burst expiry or owner dropping valid re-arbitrates in the same cycle, with no bubble.
- Backpressure: out_valid=1 and out_ready=0 → out_data/out_ch stable until accepted; no channel granted.
- Producers must hold ch_valid and data until ch_ready. The arbiter never withdraws a grant within a cycle.
- Reset mid-burst: all state returns to reset values immediately. The pending output word is discarded.

## Configuration
- FIR_ARB_FIXED_PRI_EN defined: new-grant winner is the lowest-index valid channel. ptr is unused and held at 0. Burst/MAX_BURST rules are unchanged.
- Undefined: round-robin from ptr as above (default).

## Test plan
- Reset: assert rst mid-traffic, all ch_valid=8'hFF → ch_ready=0, out_valid=0, sel=0 during reset; first grant after release is ch0.
- Fairness: ch_valid=8'hFF held, each channel streams data=ch index, MAX_BURST=4, out_ready=1 → out_ch sequence 0,0,0,0,1,1,1,1,…,7×4, then wraps to 0; one word per cycle.
- Early rotate: ch2 and ch5 valid, ch2 drops valid after 2 beats → out_ch 2,2,5,5,5,5,2,… with no idle cycle.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1, out_data=21'h1ABCD → out_data/out_ch stable, ch_ready=0, cnt unchanged; release → resumes burst count where it stopped.
- Single requester: only ch7 valid, MAX_BURST=1 → ch7 granted every cycle, ptr wraps to 0 each grant.
- FIR_ARB_FIXED_PRI_EN: ch1 and ch6 continuously valid, MAX_BURST=2 → out_ch 1,1,1,1,…; ch6 granted only once ch1 deasserts.
